// File: rtl/regfile_mp_pkg.sv
// Shared constants for the multi-port register file: default geometry,
// clear-FSM state encoding and the address-validity helper.
package regfile_mp_pkg;

  localparam int XLEN_DEF      = 32;
  localparam int REG_COUNT_DEF = 32;
  localparam int ADDR_W_DEF    = 5;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } clr_state_e;

  // Register 0 is hardwired to zero and addresses past the file are holes.
  function automatic logic addr_valid(input int a, input int reg_count);
    return (a != 0) && (a < reg_count);
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-destination scoreboard: one busy bit per register, set on issue and
// cleared by writeback. Only built when REGFILE_SCOREBOARD_EN is defined.
module regfile_scoreboard
  import regfile_mp_pkg::*;
#(
  parameter int REG_COUNT = REG_COUNT_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int NRD       = 2,
  parameter int NWR       = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ready_i,
  input  logic                  flush_i,
  input  logic                  iss_en_i,
  input  logic [ADDR_W-1:0]     iss_addr_i,
  input  logic [NWR-1:0]        wr_en_i,
  input  logic [NWR*ADDR_W-1:0] wr_addr_i,
  input  logic [NRD*ADDR_W-1:0] rd_addr_i,
  output logic [NRD-1:0]        rd_busy_o
);

  logic [REG_COUNT-1:0] busy_q, busy_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  // Writebacks clear first so a same-cycle issue to that register wins.
  always_comb begin
    busy_d = busy_q;
    if (!ready_i || flush_i) begin
      busy_d = '0;
    end else begin
      for (int p = 0; p < NWR; p++) begin
        if (wr_en_i[p] && addr_valid(int'(wr_addr_i[p*ADDR_W +: ADDR_W]), REG_COUNT))
          busy_d[wr_addr_i[p*ADDR_W +: ADDR_W]] = 1'b0;
      end
      if (iss_en_i && addr_valid(int'(iss_addr_i), REG_COUNT))
        busy_d[iss_addr_i] = 1'b1;
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              wr_hit;

    assign ra = rd_addr_i[i*ADDR_W +: ADDR_W];

    always_comb begin
      wr_hit = 1'b0;
      for (int p = 0; p < NWR; p++) begin
        if (wr_en_i[p] && (wr_addr_i[p*ADDR_W +: ADDR_W] == ra)) wr_hit = 1'b1;
      end
    end

    assign rd_busy_o[i] = ready_i && addr_valid(int'(ra), REG_COUNT) &&
                          busy_q[ra] && !wr_hit;
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with sequential clear FSM and write-to-read bypass.
// Define REGFILE_SCOREBOARD_EN to add the per-register pending scoreboard.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int XLEN      = XLEN_DEF,
  parameter int REG_COUNT = REG_COUNT_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int NRD       = 2,
  parameter int NWR       = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NRD*ADDR_W-1:0] rd_addr,
  output logic [NRD*XLEN-1:0]   rd_data,
  input  logic [NWR-1:0]        wr_en,
  input  logic [NWR*ADDR_W-1:0] wr_addr,
  input  logic [NWR*XLEN-1:0]   wr_data,
  input  logic                  clear_req,
  output logic                  ready,
  input  logic                  iss_en,
  input  logic [ADDR_W-1:0]     iss_addr,
  output logic [NRD-1:0]        rd_busy
);

  clr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [XLEN-1:0]   mem_q [REG_COUNT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_CLEAR;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      ST_CLEAR: begin
        if (idx_q == ADDR_W'(REG_COUNT - 1)) state_d = ST_READY;
        else                                 idx_d   = idx_q + 1'b1;
      end
      ST_READY: begin
        if (clear_req) begin
          state_d = ST_CLEAR;
          idx_d   = '0;
        end
      end
    endcase
  end

  assign ready = (state_q == ST_READY);

  // Ports are applied highest index first so port 0 lands last and wins.
  always_ff @(posedge clk) begin
    if (!ready) begin
      mem_q[idx_q] <= '0;
    end else begin
      for (int p = NWR - 1; p >= 0; p--) begin
        if (wr_en[p] && addr_valid(int'(wr_addr[p*ADDR_W +: ADDR_W]), REG_COUNT))
          mem_q[wr_addr[p*ADDR_W +: ADDR_W]] <= wr_data[p*XLEN +: XLEN];
      end
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [XLEN-1:0]   byp;
    logic              hit;

    assign ra = rd_addr[i*ADDR_W +: ADDR_W];

    always_comb begin
      hit = 1'b0;
      byp = '0;
      for (int p = NWR - 1; p >= 0; p--) begin
        if (wr_en[p] && (wr_addr[p*ADDR_W +: ADDR_W] == ra)) begin
          hit = 1'b1;
          byp = wr_data[p*XLEN +: XLEN];
        end
      end
    end

    assign rd_data[i*XLEN +: XLEN] =
      (!ready || !addr_valid(int'(ra), REG_COUNT)) ? '0 :
      hit                                          ? byp : mem_q[ra];
  end

`ifdef REGFILE_SCOREBOARD_EN
  regfile_scoreboard #(
    .REG_COUNT (REG_COUNT),
    .ADDR_W    (ADDR_W),
    .NRD       (NRD),
    .NWR       (NWR)
  ) u_sb (
    .clk        (clk),
    .rst        (rst),
    .ready_i    (ready),
    .flush_i    (ready && clear_req),
    .iss_en_i   (iss_en),
    .iss_addr_i (iss_addr),
    .wr_en_i    (wr_en),
    .wr_addr_i  (wr_addr),
    .rd_addr_i  (rd_addr),
    .rd_busy_o  (rd_busy)
  );
`else
  logic unused_iss;
  assign unused_iss = ^{iss_en, iss_addr};
  assign rd_busy    = '0;
`endif

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed table, clear/reset corner
// sequences and randomized traffic against a behavioural model.
`timescale 1ns/1ps
module tb_regfile_mp;
  localparam int XLEN = 32, RC = 32, AW = 5, NRD = 2, NWR = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NRD*AW-1:0]    rd_addr;
  logic [NRD*XLEN-1:0]  rd_data;
  logic [NWR-1:0]       wr_en;
  logic [NWR*AW-1:0]    wr_addr;
  logic [NWR*XLEN-1:0]  wr_data;
  logic                 clear_req;
  logic                 ready;
  logic                 iss_en;
  logic [AW-1:0]        iss_addr;
  logic [NRD-1:0]       rd_busy;

  regfile_mp #(.XLEN(XLEN), .REG_COUNT(RC), .ADDR_W(AW), .NRD(NRD), .NWR(NWR)) dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .clear_req(clear_req), .ready(ready),
    .iss_en(iss_en), .iss_addr(iss_addr), .rd_busy(rd_busy)
  );

  always #5 clk = ~clk;

  int n_pass = 0, n_total = 0;

  // Behavioural model: register contents, pending set, clear cycles remaining.
  logic [XLEN-1:0] m_mem [RC];
  bit              m_busy [RC];
  int              m_left;

  typedef struct {
    logic [1:0]      we;
    logic [AW-1:0]   wa0, wa1;
    logic [XLEN-1:0] wd0, wd1;
    logic [AW-1:0]   ra0, ra1;
    logic [XLEN-1:0] e0, e1;
  } vec_t;
  vec_t tbl [9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [XLEN-1:0] exp_rd(input logic [AW-1:0] a);
    if (m_left != 0 || a == 0 || int'(a) >= RC) return '0;
    for (int p = 0; p < NWR; p++)
      if (wr_en[p] && wr_addr[p*AW +: AW] == a) return wr_data[p*XLEN +: XLEN];
    return m_mem[a];
  endfunction

  function automatic logic exp_busy(input logic [AW-1:0] a);
`ifdef REGFILE_SCOREBOARD_EN
    if (m_left != 0 || a == 0 || int'(a) >= RC) return 1'b0;
    for (int p = 0; p < NWR; p++)
      if (wr_en[p] && wr_addr[p*AW +: AW] == a) return 1'b0;
    return m_busy[a];
`else
    return (a == 0) && (a != 0);
`endif
  endfunction

  task automatic model_reset();
    m_left = RC;
    for (int r = 0; r < RC; r++) m_busy[r] = 1'b0;
  endtask

  task automatic model_step();
    logic [AW-1:0] a;
    bit            taken [RC];
    if (m_left > 0) begin
      m_mem[RC - m_left] = '0;
      m_left--;
      return;
    end
    for (int r = 0; r < RC; r++) taken[r] = 1'b0;
    for (int p = 0; p < NWR; p++) begin
      a = wr_addr[p*AW +: AW];
      if (wr_en[p] && a != 0 && int'(a) < RC) begin
        if (!taken[a]) m_mem[a] = wr_data[p*XLEN +: XLEN];
        taken[a] = 1'b1;
        m_busy[a] = 1'b0;
      end
    end
    if (iss_en && iss_addr != 0 && int'(iss_addr) < RC) m_busy[iss_addr] = 1'b1;
    if (clear_req) model_reset();
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else     model_step();
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = '0; wr_addr = '0; wr_data = '0; rd_addr = '0;
    clear_req = 1'b0; iss_en = 1'b0; iss_addr = '0;
  endtask

  task automatic check_all(input string tag);
    check({tag, "_ready"}, ready, (m_left == 0));
    for (int i = 0; i < NRD; i++) begin
      check($sformatf("%s_rd%0d", tag, i), rd_data[i*XLEN +: XLEN], exp_rd(rd_addr[i*AW +: AW]));
      check($sformatf("%s_busy%0d", tag, i), rd_busy[i], exp_busy(rd_addr[i*AW +: AW]));
    end
  endtask

  task automatic wait_ready(input string name);
    int cnt = 0;
    while (!ready && cnt < 100) begin
      tick();
      cnt++;
    end
    check(name, cnt, 32);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{2'b11, 5'd5,  5'd5,  32'hAAAA, 32'h5555, 5'd5,  5'd5,  32'hAAAA, 32'hAAAA};
    tbl[1] = '{2'b00, 5'd0,  5'd0,  32'h0,    32'h0,    5'd5,  5'd0,  32'hAAAA, 32'h0};
    tbl[2] = '{2'b01, 5'd0,  5'd0,  32'hFFFF, 32'h0,    5'd0,  5'd0,  32'h0,    32'h0};
    tbl[3] = '{2'b00, 5'd0,  5'd0,  32'h0,    32'h0,    5'd0,  5'd0,  32'h0,    32'h0};
    tbl[4] = '{2'b10, 5'd0,  5'd9,  32'h0,    32'h1111, 5'd9,  5'd5,  32'h1111, 32'hAAAA};
    tbl[5] = '{2'b11, 5'd9,  5'd12, 32'h2222, 32'h3333, 5'd12, 5'd9,  32'h3333, 32'h2222};
    tbl[6] = '{2'b00, 5'd0,  5'd0,  32'h0,    32'h0,    5'd12, 5'd9,  32'h3333, 32'h2222};
    tbl[7] = '{2'b01, 5'd31, 5'd0,  32'hDEAD, 32'h0,    5'd31, 5'd31, 32'hDEAD, 32'hDEAD};
    tbl[8] = '{2'b00, 5'd0,  5'd0,  32'h0,    32'h0,    5'd31, 5'd30, 32'hDEAD, 32'h0};

    rst = 1'b1;
    idle();
    for (int r = 0; r < RC; r++) m_mem[r] = '0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check("reset_ready", ready, 0);
    check("reset_rd_data", rd_data, 0);
    check("reset_busy", rd_busy, 0);
    rst = 1'b0;
    wait_ready("init_clear_cycles");
    for (int a = 1; a < RC; a += 10) begin
      rd_addr = {AW'(a + 1), AW'(a)};
      #1 check($sformatf("init_zero_r%0d", a), rd_data, 0);
    end
    idle();

    // Directed table: priority, register 0 and bypass.
    for (int i = 0; i < $size(tbl); i++) begin
      idle();
      wr_en   = tbl[i].we;
      wr_addr = {tbl[i].wa1, tbl[i].wa0};
      wr_data = {tbl[i].wd1, tbl[i].wd0};
      rd_addr = {tbl[i].ra1, tbl[i].ra0};
      #1;
      check($sformatf("vec%0d_rd0", i), rd_data[XLEN-1:0], tbl[i].e0);
      check($sformatf("vec%0d_rd1", i), rd_data[2*XLEN-1:XLEN], tbl[i].e1);
      tick();
    end
    idle();

    // Clear request: ready drops, writes during clear are dropped.
    wr_en = 2'b01; wr_addr[AW-1:0] = 5'd7; wr_data[XLEN-1:0] = 32'h1234;
    tick();
    idle(); rd_addr[AW-1:0] = 5'd7;
    #1 check("r7_loaded", rd_data[XLEN-1:0], 32'h1234);
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    check("clr_ready_drop", ready, 0);
    begin
      int cnt = 0;
      while (!ready && cnt < 100) begin
        wr_en = 2'b01; wr_addr[AW-1:0] = 5'd7; wr_data[XLEN-1:0] = 32'hBEEF;
        rd_addr[AW-1:0] = 5'd7;
        clear_req = (cnt == 3);
        #1;
        if (cnt == 5 || cnt == 31) check_all($sformatf("clr_c%0d", cnt));
        tick();
        cnt++;
      end
      check("clr_cycles", cnt, 32);
    end
    idle(); rd_addr[AW-1:0] = 5'd7;
    #1 check("r7_cleared", rd_data[XLEN-1:0], 0);

    // Reset in the middle of a clear restarts it from index 0.
    idle(); clear_req = 1'b1;
    tick();
    idle();
    repeat (10) tick();
    rst = 1'b1;
    model_reset();
    #1 check("midrst_ready", ready, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    wait_ready("midrst_restart_cycles");

    // Scoreboard set/clear interplay on register 3.
    idle(); iss_en = 1'b1; iss_addr = 5'd3;
    tick();
    idle(); rd_addr[AW-1:0] = 5'd3;
`ifdef REGFILE_SCOREBOARD_EN
    #1 check("sb_set", rd_busy[0], 1);
    wr_en = 2'b01; wr_addr[AW-1:0] = 5'd3; wr_data[XLEN-1:0] = 32'h77;
    #1 check("sb_wr_same_cycle", rd_busy[0], 0);
    check("sb_wr_bypass", rd_data[XLEN-1:0], 32'h77);
    tick();
    idle(); rd_addr[AW-1:0] = 5'd3;
    #1 check("sb_cleared", rd_busy[0], 0);
    iss_en = 1'b1; iss_addr = 5'd3;
    wr_en = 2'b01; wr_addr[AW-1:0] = 5'd3; wr_data[XLEN-1:0] = 32'h88;
    tick();
    idle(); rd_addr[AW-1:0] = 5'd3;
    #1 check("sb_set_wins", rd_busy[0], 1);
    check("sb_set_wins_data", rd_data[XLEN-1:0], 32'h88);
`else
    #1 check("nosb_busy_tied", rd_busy, 0);
`endif
    idle();

    // Randomized traffic against the model.
    for (int c = 0; c < 600; c++) begin
      wr_en     = NWR'($urandom_range(0, 3));
      wr_addr   = {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7))};
      wr_data   = {$urandom, $urandom};
      rd_addr   = {AW'($urandom_range(0, 9)), AW'($urandom_range(0, 9))};
      iss_en    = ($urandom_range(0, 1) == 1);
      iss_addr  = AW'($urandom_range(0, 7));
      clear_req = ($urandom_range(0, 99) == 0);
      #1 check_all($sformatf("rnd%0d", c));
      tick();
    end
    idle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
